// File: rtl/rst_sequencer_pkg.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | rst_seq_pkg : state encoding and widths for the reset sequencer    |
// | Rev 1.0                                                            |
// +--------------------------------------------------------------------+
package rst_seq_pkg;

  localparam int STATE_W = 3;
  localparam int RETRY_W = 4;

  typedef enum logic [STATE_W-1:0] {
    S_RST        = 3'd0,
    S_WAIT_LOCK  = 3'd1,
    S_DDR_RST    = 3'd2,
    S_WAIT_CALIB = 3'd3,
    S_WB_REL     = 3'd4,
    S_RUN        = 3'd5
  } seq_state_t;

endpackage
`default_nettype wire

// File: rtl/rst_sequencer_if.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | rst_sequencer_if : status inputs and reset outputs of the sequencer|
// | Rev 1.0 -- soft_rst_i present only with RST_SEQ_SOFT_RST_EN        |
// +--------------------------------------------------------------------+
interface rst_sequencer_if;
  import rst_seq_pkg::*;

  logic               dcm_locked_i;
  logic               ddr2_calib_done_i;
  logic               ddr2_if_rst_o;
  logic               wb_rst_o;
  logic               cpu_rst_o;
  logic [STATE_W-1:0] seq_state_o;
  logic [RETRY_W-1:0] calib_retry_o;
  logic               calib_fail_o;
`ifdef RST_SEQ_SOFT_RST_EN
  logic               soft_rst_i;
`endif

  modport slave (
`ifdef RST_SEQ_SOFT_RST_EN
    input  soft_rst_i,
`endif
    input  dcm_locked_i,
    input  ddr2_calib_done_i,
    output ddr2_if_rst_o,
    output wb_rst_o,
    output cpu_rst_o,
    output seq_state_o,
    output calib_retry_o,
    output calib_fail_o
  );

  modport master (
`ifdef RST_SEQ_SOFT_RST_EN
    output soft_rst_i,
`endif
    output dcm_locked_i,
    output ddr2_calib_done_i,
    input  ddr2_if_rst_o,
    input  wb_rst_o,
    input  cpu_rst_o,
    input  seq_state_o,
    input  calib_retry_o,
    input  calib_fail_o
  );

endinterface
`default_nettype wire

// File: rtl/rst_sequencer_sync_bit.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | sync_bit : SYNC_STAGES-deep resettable single-bit synchronizer     |
// | Rev 1.0                                                            |
// +--------------------------------------------------------------------+
module sync_bit #(
  parameter int SYNC_STAGES = 2
) (
  input  wire logic clk,
  input  wire logic rst,
  input  wire logic i_d,
  output logic      o_q
);

  logic [SYNC_STAGES-1:0] r_sync;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_sync <= '0;
    end else begin
      r_sync <= {r_sync[SYNC_STAGES-2:0], i_d};
    end
  end

  assign o_q = r_sync[SYNC_STAGES-1];

endmodule
`default_nettype wire

// File: rtl/rst_sequencer.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | rst_sequencer : ordered DDR2 / Wishbone / CPU reset release        |
// | Rev 1.0 -- RST_SEQ_SOFT_RST_EN adds a soft CPU/fabric reset        |
// +--------------------------------------------------------------------+
module rst_sequencer
  import rst_seq_pkg::*;
#(
  parameter int SYNC_STAGES    = 2,
  parameter int LOCK_HOLD      = 1024,
  parameter int DDR_RST_CYCLES = 64,
  parameter int CALIB_TIMEOUT  = 1048576,
  parameter int CPU_HOLD       = 16,
  parameter int CNT_W          = 21
) (
  input  wire logic      wb_clk_i,
  input  wire logic      async_rst_i,
  rst_sequencer_if.slave bus
);

  localparam logic [CNT_W-1:0]   c_lock_max  = CNT_W'(LOCK_HOLD - 1);
  localparam logic [CNT_W-1:0]   c_ddr_max   = CNT_W'(DDR_RST_CYCLES - 1);
  localparam logic [CNT_W-1:0]   c_calib_max = CNT_W'(CALIB_TIMEOUT - 1);
  localparam logic [CNT_W-1:0]   c_cpu_max   = CNT_W'(CPU_HOLD - 1);
  localparam logic [CNT_W-1:0]   c_cnt_one   = CNT_W'(1);
  localparam logic [RETRY_W-1:0] c_retry_max = '1;

  logic               w_lock_s;
  logic               w_calib_s;
  seq_state_t         w_state_nxt;
  logic [CNT_W-1:0]   w_cnt_nxt;
  logic               w_timeout;
  logic               w_soft_entry;

  seq_state_t         r_state;
  logic [CNT_W-1:0]   r_cnt;
  logic [RETRY_W-1:0] r_retry;
  logic               r_fail;
  logic               r_ddr;
  logic               r_wb;
  logic               r_cpu;

`ifdef RST_SEQ_SOFT_RST_EN
  logic               r_soft_d;
  logic               r_soft_hold;
  logic               w_soft_rise;

  assign w_soft_rise = bus.soft_rst_i & ~r_soft_d;
`endif

  sync_bit #(.SYNC_STAGES(SYNC_STAGES)) u_sync_lock (
    .clk (wb_clk_i),
    .rst (async_rst_i),
    .i_d (bus.dcm_locked_i),
    .o_q (w_lock_s)
  );

  sync_bit #(.SYNC_STAGES(SYNC_STAGES)) u_sync_calib (
    .clk (wb_clk_i),
    .rst (async_rst_i),
    .i_d (bus.ddr2_calib_done_i),
    .o_q (w_calib_s)
  );

  always_comb begin
    w_state_nxt  = r_state;
    w_cnt_nxt    = r_cnt;
    w_timeout    = 1'b0;
    w_soft_entry = 1'b0;
    case (r_state)
      S_RST: w_state_nxt = S_WAIT_LOCK;
      S_WAIT_LOCK: begin
        if (!w_lock_s)                w_cnt_nxt   = '0;
        else if (r_cnt == c_lock_max) w_state_nxt = S_DDR_RST;
        else                          w_cnt_nxt   = r_cnt + c_cnt_one;
      end
      S_DDR_RST: begin
        if (r_cnt == c_ddr_max) w_state_nxt = S_WAIT_CALIB;
        else                    w_cnt_nxt   = r_cnt + c_cnt_one;
      end
      S_WAIT_CALIB: begin
        // Calibration completing on the timeout cycle still counts as success.
        if (w_calib_s) begin
          w_state_nxt = S_WB_REL;
        end else if (r_cnt == c_calib_max) begin
          w_state_nxt = S_DDR_RST;
          w_timeout   = 1'b1;
        end else begin
          w_cnt_nxt   = r_cnt + c_cnt_one;
        end
      end
      S_WB_REL: begin
        if (!w_calib_s)              w_state_nxt = S_DDR_RST;
`ifdef RST_SEQ_SOFT_RST_EN
        else if (r_soft_hold)        w_cnt_nxt   = r_cnt;
`endif
        else if (r_cnt == c_cpu_max) w_state_nxt = S_RUN;
        else                         w_cnt_nxt   = r_cnt + c_cnt_one;
      end
      S_RUN: begin
        if (!w_calib_s) begin
          w_state_nxt = S_DDR_RST;
`ifdef RST_SEQ_SOFT_RST_EN
        end else if (w_soft_rise) begin
          w_state_nxt  = S_WB_REL;
          w_soft_entry = 1'b1;
`endif
        end
      end
      default: w_state_nxt = S_RST;
    endcase

    if (!w_lock_s && (r_state inside {S_DDR_RST, S_WAIT_CALIB, S_WB_REL, S_RUN})) begin
      w_state_nxt  = S_WAIT_LOCK;
      w_timeout    = 1'b0;
      w_soft_entry = 1'b0;
    end

    if (w_state_nxt != r_state) w_cnt_nxt = '0;
  end

  // Outputs are decoded from the next state so they move with the state register.
  always_ff @(posedge wb_clk_i or posedge async_rst_i) begin
    if (async_rst_i) begin
      r_state     <= S_RST;
      r_cnt       <= '0;
      r_retry     <= '0;
      r_fail      <= 1'b0;
      r_ddr       <= 1'b1;
      r_wb        <= 1'b1;
      r_cpu       <= 1'b1;
`ifdef RST_SEQ_SOFT_RST_EN
      r_soft_d    <= 1'b0;
      r_soft_hold <= 1'b0;
`endif
    end else begin
      r_state <= w_state_nxt;
      r_cnt   <= w_cnt_nxt;
      if (w_timeout) begin
        r_fail <= 1'b1;
        if (r_retry != c_retry_max) r_retry <= r_retry + RETRY_W'(1);
      end
      r_ddr <= (w_state_nxt == S_RST) || (w_state_nxt == S_WAIT_LOCK) ||
               (w_state_nxt == S_DDR_RST);
      r_wb  <= !((w_state_nxt == S_WB_REL) || (w_state_nxt == S_RUN)) || w_soft_entry;
      r_cpu <= (w_state_nxt != S_RUN);
`ifdef RST_SEQ_SOFT_RST_EN
      r_soft_d    <= bus.soft_rst_i;
      r_soft_hold <= w_soft_entry;
`endif
    end
  end

  assign bus.ddr2_if_rst_o = r_ddr;
  assign bus.wb_rst_o      = r_wb;
  assign bus.cpu_rst_o     = r_cpu;
  assign bus.seq_state_o   = r_state;
  assign bus.calib_retry_o = r_retry;
  assign bus.calib_fail_o  = r_fail;

endmodule
`default_nettype wire
